key_event_ctrl: RTL and testbench
=================================

// Module: key_event_ctrl
// PURPOSE
//  Front-end controller for the board push-buttons. Debounces NUM_KEYS active-low keys, classifies
//  press / long-press / release, and round-robin arbitrates them onto one event stream (valid/ready).
//  Replaces scattered per-key debouncers. Feeds mode/config logic (e.g. camera/eth control).
// PARAMETERS
//  NUM_KEYS   4           number of keys (2..8)
//  HOLD_TIME  50_000      consecutive stable cycles to accept a level change (1 ms @ 50 MHz)
//  LONG_TIME  50_000_000  cycles held (counted from press accept) to raise LONG (1 s @ 50 MHz)
// PORTS
//  clk        in   1           system clock
//  rst        in   1           synchronous, active-high reset
//  key_i      in   NUM_KEYS    raw keys, asynchronous, 0 = pressed
//  evt_valid  out  1           event available
//  evt_ready  in   1           consumer accepts event when evt_valid & evt_ready
//  evt_key    out  3           index of key that produced the event
//  evt_code   out  2           01 PRESS, 10 LONG, 11 RELEASE (00 never output)
//  key_state  out  NUM_KEYS    debounced level, 1 = held
//  evt_drop   out  1           sticky: an event was lost; cleared only by rst
// BEHAVIOUR
//  Reset: all outputs 0; all key FSMs IDLE; counters 0; pending slots empty; RR pointer 0.
//  Sync: each key_i bit passes 2 flops; FSM sees key_s (2-cycle delay), active-low.
//  Per-key FSM (32-bit counter cnt):
//   IDLE: key_s==0 -> cnt++, else cnt=0. cnt==HOLD_TIME-1 with key_s==0 -> PRESSED, post PRESS, cnt=0.
//   PRESSED: key_s==1 -> REL_DB, cnt=0. Else cnt++; cnt==LONG_TIME-1 -> LONG, post LONG.
//   LONG: key_s==1 -> REL_DB, cnt=0. Else hold (no repeat).
//   REL_DB: key_s==1 -> cnt++; key_s==0 -> back to PRESSED if no LONG posted, else LONG; cnt=0
//     (bounce ignored, long timer restarts). cnt==HOLD_TIME-1 with key_s==1 -> IDLE, post RELEASE.
//   key_state bit = 1 in PRESSED, LONG, REL_DB.
//   "LONG posted" is a per-key flag, set on LONG and cleared on entry to IDLE.
//  Pending slot: one 2-bit code per key. Post into an empty slot fills it.
//   Post into a full slot: the old event is kept, the new one is dropped, evt_drop=1.
//   A slot drained in the same cycle as a post accepts the new event (no drop).
//  Arbiter / output register:
//   When the output register is empty, or fires (valid&ready) this cycle, load the first full slot
//     searching from RR pointer upward, wrapping at NUM_KEYS-1 -> 0.
//   RR pointer = granted index + 1 (mod NUM_KEYS). Slot clears on grant.
//   Latency: post -> evt_valid next cycle if the register is free. Back-to-back one event/cycle under ready=1.
//   evt_valid/evt_key/evt_code stable while valid & !ready. No combinational ready->valid path.
//  Arithmetic: cnt saturates (never wraps); evt_key zero-extended to 3 bits.
//  Reset mid-press: FSM -> IDLE. A still-held key must re-qualify HOLD_TIME before PRESS.
//  No RELEASE is emitted for a key interrupted by reset.
// TESTING (HOLD_TIME=4, LONG_TIME=16, NUM_KEYS=4, ready=1 unless stated)
//  1 key0 low 3 cycles then high -> no event, key_state=0.
//    key0 low 10 cycles -> PRESS(key0) on evt 4+2+1 cycles after fall, key_state[0]=1.
//  2 key1 held 30 cycles then released -> PRESS, LONG at press+16, RELEASE after 4 high cycles; LONG exactly once.
//  3 keys 0,2,3 accepted same cycle, RR ptr=2 -> order key2, key3, key0 on 3 consecutive cycles.
//  4 ready=0, key0 press then release -> PRESS held stable; RELEASE waits in slot.
//    2nd press while full -> evt_drop=1, later events unaffected.
//  5 key2 pressed, 2-cycle high glitch inside hold -> no RELEASE, still PRESSED; long timer restarts.
//  6 rst=1 mid-LONG for 1 cycle, key still low -> outputs 0; new PRESS after 4+2 cycles, no RELEASE.

Source files
------------

// File: rtl/key_event_ctrl.sv
// key_event_ctrl: debounces NUM_KEYS active-low push-buttons and classifies
// press / long-press / release per key. Events go through one pending slot per
// key and a round-robin arbiter into a single valid/ready output register.

// Per-key debounce and classify FSM; post pulses for one cycle with the code.
module key_event_fsm #(
    parameter int HOLD_TIME = 50_000,
    parameter int LONG_TIME = 50_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_s,      // synchronized raw level, 0 = pressed
    output logic       post,
    output logic [1:0] post_code,
    output logic       held
);
    localparam logic [1:0]  CODE_PRESS   = 2'b01;
    localparam logic [1:0]  CODE_LONG    = 2'b10;
    localparam logic [1:0]  CODE_RELEASE = 2'b11;
    localparam logic [31:0] HOLD_LAST    = 32'(HOLD_TIME - 1);
    localparam logic [31:0] LONG_LAST    = 32'(LONG_TIME - 1);

    typedef enum logic [1:0] {S_IDLE, S_PRESSED, S_LONG, S_REL_DB} state_t;

    state_t      state, state_nx;
    logic [31:0] cnt, cnt_nx, cnt_inc;
    logic        long_posted, long_posted_nx;

    // counter never wraps; it simply parks at all-ones
    assign cnt_inc = (cnt == '1) ? cnt : cnt + 32'd1;
    assign held    = (state != S_IDLE);

    // state, counter and long flag registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            cnt         <= '0;
            long_posted <= 1'b0;
        end else begin
            state       <= state_nx;
            cnt         <= cnt_nx;
            long_posted <= long_posted_nx;
        end
    end

    // next-state, counter update and event posting
    always_comb begin
        state_nx       = state;
        cnt_nx         = cnt;
        long_posted_nx = long_posted;
        post           = 1'b0;
        post_code      = 2'b00;
        case (state)
            S_IDLE: begin
                if (!key_s) begin
                    if (cnt == HOLD_LAST) begin
                        state_nx  = S_PRESSED;
                        cnt_nx    = '0;
                        post      = 1'b1;
                        post_code = CODE_PRESS;
                    end else begin
                        cnt_nx = cnt_inc;
                    end
                end else begin
                    cnt_nx = '0;
                end
            end
            S_PRESSED: begin
                if (key_s) begin
                    state_nx = S_REL_DB;
                    cnt_nx   = '0;
                end else if (cnt == LONG_LAST) begin
                    state_nx       = S_LONG;
                    cnt_nx         = '0;
                    long_posted_nx = 1'b1;
                    post           = 1'b1;
                    post_code      = CODE_LONG;
                end else begin
                    cnt_nx = cnt_inc;
                end
            end
            S_LONG: begin
                // no auto-repeat: sit here until the key lifts
                if (key_s) begin
                    state_nx = S_REL_DB;
                    cnt_nx   = '0;
                end
            end
            S_REL_DB: begin
                if (key_s) begin
                    if (cnt == HOLD_LAST) begin
                        state_nx       = S_IDLE;
                        cnt_nx         = '0;
                        long_posted_nx = 1'b0;
                        post           = 1'b1;
                        post_code      = CODE_RELEASE;
                    end else begin
                        cnt_nx = cnt_inc;
                    end
                end else begin
                    // bounce during release: resume holding, long timer restarts
                    state_nx = long_posted ? S_LONG : S_PRESSED;
                    cnt_nx   = '0;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end
endmodule

module key_event_ctrl #(
    parameter int NUM_KEYS  = 4,
    parameter int HOLD_TIME = 50_000,
    parameter int LONG_TIME = 50_000_000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_KEYS-1:0] key_i,
    output logic                evt_valid,
    input  logic                evt_ready,
    output logic [2:0]          evt_key,
    output logic [1:0]          evt_code,
    output logic [NUM_KEYS-1:0] key_state,
    output logic                evt_drop
);
    localparam int            IW       = $clog2(NUM_KEYS);
    localparam logic [IW:0]   NK       = (IW+1)'(NUM_KEYS);
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_KEYS - 1);

    typedef struct packed {
        logic [2:0] key;
        logic [1:0] code;
    } evt_t;

    logic [NUM_KEYS-1:0]       sync1, key_s;
    logic [NUM_KEYS-1:0]       post;
    logic [NUM_KEYS-1:0][1:0]  post_code;
    logic [NUM_KEYS-1:0][1:0]  slot;        // 00 = empty
    logic [NUM_KEYS-1:0]       drain;
    logic [IW-1:0]             rr;
    logic [IW-1:0]             gnt_idx;
    logic                      gnt_found;
    logic [IW:0]               scan;
    logic                      load_en;
    evt_t                      evt_q;

    assign evt_key  = evt_q.key;
    assign evt_code = evt_q.code;
    // output register may take a new event when empty or being consumed now
    assign load_en  = !evt_valid || evt_ready;

    // two-flop synchronizer; resets to the released level so a held key re-qualifies
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= '1;
            key_s <= '1;
        end else begin
            sync1 <= key_i;
            key_s <= sync1;
        end
    end

    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
        key_event_fsm #(
            .HOLD_TIME (HOLD_TIME),
            .LONG_TIME (LONG_TIME)
        ) u_fsm (
            .clk       (clk),
            .rst       (rst),
            .key_s     (key_s[k]),
            .post      (post[k]),
            .post_code (post_code[k]),
            .held      (key_state[k])
        );
    end

    // round-robin search for the first full slot at or above rr, wrapping
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        scan      = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            scan = {1'b0, rr} + (IW+1)'(i);
            if (scan >= NK) scan = scan - NK;
            if (!gnt_found && slot[scan[IW-1:0]] != 2'b00) begin
                gnt_found = 1'b1;
                gnt_idx   = scan[IW-1:0];
            end
        end
    end

    // one-hot of the slot being moved into the output register this cycle
    always_comb begin
        drain = '0;
        if (load_en && gnt_found) drain[gnt_idx] = 1'b1;
    end

    // pending slots: a post lands if the slot is empty or draining now, else it is lost
    always_ff @(posedge clk) begin
        if (rst) begin
            slot     <= '0;
            evt_drop <= 1'b0;
        end else begin
            for (int k = 0; k < NUM_KEYS; k++) begin
                if (post[k]) begin
                    if (slot[k] == 2'b00 || drain[k]) slot[k] <= post_code[k];
                    else                              evt_drop <= 1'b1;
                end else if (drain[k]) begin
                    slot[k] <= 2'b00;
                end
            end
        end
    end

    // output register and round-robin pointer
    always_ff @(posedge clk) begin
        if (rst) begin
            evt_valid <= 1'b0;
            evt_q     <= '0;
            rr        <= '0;
        end else if (load_en) begin
            evt_valid <= gnt_found;
            if (gnt_found) begin
                evt_q.key  <= 3'(gnt_idx);
                evt_q.code <= slot[gnt_idx];
                rr         <= (gnt_idx == LAST_IDX) ? '0 : gnt_idx + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_key_event_ctrl.sv
// Bench for key_event_ctrl: directed scenarios followed by a random phase, every
// cycle checked against a behavioural model built from run-length counts.
module tb_key_event_ctrl;
    localparam int NK    = 4;
    localparam int HOLD  = 4;
    localparam int LONG  = 16;
    localparam int PRESS = 1;
    localparam int LNG   = 2;
    localparam int REL   = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic [NK-1:0] key_i;
    logic          evt_valid;
    logic          evt_ready;
    logic [2:0]    evt_key;
    logic [1:0]    evt_code;
    logic [NK-1:0] key_state;
    logic          evt_drop;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // model state: sync pipe, held flag, run lengths, pending slots, output
    int m_s1 [NK];
    int m_s2 [NK];
    bit m_held [NK];
    bit m_lp [NK];
    int m_lo [NK];
    int m_hi [NK];
    int m_tmr [NK];
    int m_slot [NK];
    bit m_vld;
    bit m_drop;
    int m_key;
    int m_code;
    int m_rr;

    int obs [$];     // events consumed from the DUT, key*4+code
    int obs_t [$];   // cycle of each consumption
    int exp_q [$];

    always #5 clk = ~clk;

    key_event_ctrl #(.NUM_KEYS(NK), .HOLD_TIME(HOLD), .LONG_TIME(LONG)) dut (
        .clk       (clk),
        .rst       (rst),
        .key_i     (key_i),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_key   (evt_key),
        .evt_code  (evt_code),
        .key_state (key_state),
        .evt_drop  (evt_drop)
    );

    function automatic void chk(string tag, logic [31:0] o, logic [31:0] e);
        n_cmp++;
        assert (o === e) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, o, e);
        end
    endfunction

    function automatic int ev(int k, int c);
        return k * 4 + c;
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < NK; k++) begin
            m_s1[k] = 1; m_s2[k] = 1; m_held[k] = 0; m_lp[k] = 0;
            m_lo[k] = 0; m_hi[k] = 0; m_tmr[k] = 0; m_slot[k] = 0;
        end
        m_vld = 0; m_drop = 0; m_key = 0; m_code = 0; m_rr = 0;
    endfunction

    // one clock edge of the reference behaviour
    function automatic void model_step();
        int post [NK];
        int gnt;
        if (rst) begin
            model_reset();
            return;
        end
        for (int k = 0; k < NK; k++) begin
            post[k] = 0;
            if (!m_held[k]) begin
                // HOLD consecutive low samples accept a press
                if (m_s2[k] == 0) begin
                    m_lo[k]++;
                    if (m_lo[k] == HOLD) begin
                        m_held[k] = 1; m_lo[k] = 0; m_tmr[k] = 0; m_hi[k] = 0;
                        post[k] = PRESS;
                    end
                end else m_lo[k] = 0;
            end else if (m_s2[k] == 1) begin
                // first high sample leaves the held phase, then HOLD more qualify the release
                m_hi[k]++;
                if (m_hi[k] == HOLD + 1) begin
                    m_held[k] = 0; m_lp[k] = 0; m_hi[k] = 0;
                    post[k] = REL;
                end
            end else if (m_hi[k] > 0) begin
                // bounce back to low: long timer starts over, this sample not counted
                m_hi[k] = 0; m_tmr[k] = 0;
            end else if (!m_lp[k]) begin
                m_tmr[k]++;
                if (m_tmr[k] == LONG) begin
                    m_lp[k] = 1;
                    post[k] = LNG;
                end
            end
        end
        if (!m_vld || evt_ready) begin
            gnt = -1;
            for (int i = 0; i < NK; i++) begin
                int j;
                j = (m_rr + i) % NK;
                if (gnt < 0 && m_slot[j] != 0) gnt = j;
            end
            if (gnt >= 0) begin
                m_vld = 1; m_key = gnt; m_code = m_slot[gnt];
                m_slot[gnt] = 0; m_rr = (gnt + 1) % NK;
            end else m_vld = 0;
        end
        for (int k = 0; k < NK; k++) begin
            if (post[k] != 0) begin
                if (m_slot[k] == 0) m_slot[k] = post[k];
                else                m_drop = 1;
            end
        end
        for (int k = 0; k < NK; k++) begin
            m_s2[k] = m_s1[k];
            m_s1[k] = int'(key_i[k]);
        end
    endfunction

    task automatic compare();
        logic [NK-1:0] ks;
        for (int k = 0; k < NK; k++) ks[k] = m_held[k];
        chk("evt_valid", 32'(evt_valid), 32'(m_vld));
        if (m_vld) begin
            chk("evt_key", 32'(evt_key), 32'(m_key));
            chk("evt_code", 32'(evt_code), 32'(m_code));
        end
        chk("key_state", 32'(key_state), 32'(ks));
        chk("evt_drop", 32'(evt_drop), 32'(m_drop));
    endtask

    task automatic tick();
        if (evt_valid && evt_ready && !rst) begin
            obs.push_back(ev(int'(evt_key), int'(evt_code)));
            obs_t.push_back(cyc);
        end
        @(posedge clk);
        cyc++;
        model_step();
        #1;
        compare();
    endtask

    task automatic ticks(int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!evt_valid && n < 40) begin
            tick();
            n++;
        end
    endtask

    task automatic check_events(string tag);
        chk({tag, "_count"}, obs.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs.size(); i++) chk(tag, obs[i], exp_q[i]);
        obs.delete();
        obs_t.delete();
        exp_q.delete();
    endtask

    initial begin
        int n;
        model_reset();
        rst = 1'b1; key_i = '1; evt_ready = 1'b1;
        ticks(2);
        chk("rst_valid", 32'(evt_valid), 0);
        chk("rst_key", 32'(evt_key), 0);
        chk("rst_code", 32'(evt_code), 0);
        chk("rst_state", 32'(key_state), 0);
        chk("rst_drop", 32'(evt_drop), 0);
        rst = 1'b0;
        ticks(2);

        // too-short press is ignored; a real one reaches evt 4+2+1 cycles after the fall
        key_i[0] = 0; ticks(3); key_i[0] = 1; ticks(10);
        chk("s1_short_state", 32'(key_state), 0);
        chk("s1_short_events", obs.size(), 0);
        key_i[0] = 0;
        wait_valid(n);
        chk("s1_press_lat", n, 7);
        chk("s1_press_key", 32'(evt_key), 0);
        chk("s1_press_code", 32'(evt_code), PRESS);
        ticks(3);
        chk("s1_held", 32'(key_state[0]), 1);
        key_i[0] = 1; ticks(12);
        exp_q.push_back(ev(0, PRESS)); exp_q.push_back(ev(0, REL));
        check_events("s1_events");

        // long hold: LONG exactly once, 16 cycles after PRESS
        key_i[1] = 0; ticks(30); key_i[1] = 1; ticks(12);
        if (obs_t.size() >= 2) chk("s2_long_gap", obs_t[1] - obs_t[0], LONG);
        else chk("s2_long_gap", obs_t.size(), 2);
        exp_q.push_back(ev(1, PRESS)); exp_q.push_back(ev(1, LNG)); exp_q.push_back(ev(1, REL));
        check_events("s2_events");

        // simultaneous presses with the pointer at 2 come out 2, 3, 0 back to back
        key_i[0] = 0; key_i[2] = 0; key_i[3] = 0; ticks(10);
        key_i = '1; ticks(14);
        if (obs_t.size() >= 3) begin
            chk("s3_gap01", obs_t[1] - obs_t[0], 1);
            chk("s3_gap12", obs_t[2] - obs_t[1], 1);
        end else chk("s3_gaps", obs_t.size(), 6);
        exp_q.push_back(ev(2, PRESS)); exp_q.push_back(ev(3, PRESS)); exp_q.push_back(ev(0, PRESS));
        exp_q.push_back(ev(2, REL));   exp_q.push_back(ev(3, REL));   exp_q.push_back(ev(0, REL));
        check_events("s3_events");

        // back-pressure: PRESS held, RELEASE parked, second press lost
        evt_ready = 0;
        key_i[0] = 0; ticks(10); key_i[0] = 1; ticks(12);
        chk("s4_hold_valid", 32'(evt_valid), 1);
        chk("s4_hold_key", 32'(evt_key), 0);
        chk("s4_hold_code", 32'(evt_code), PRESS);
        chk("s4_no_drop_yet", 32'(evt_drop), 0);
        key_i[0] = 0; ticks(10);
        chk("s4_drop", 32'(evt_drop), 1);
        chk("s4_still_code", 32'(evt_code), PRESS);
        key_i[0] = 1; ticks(12);
        evt_ready = 1; ticks(4);
        exp_q.push_back(ev(0, PRESS)); exp_q.push_back(ev(0, REL));
        check_events("s4_drain");
        key_i[0] = 0; ticks(10); key_i[0] = 1; ticks(12);
        exp_q.push_back(ev(0, PRESS)); exp_q.push_back(ev(0, REL));
        check_events("s4_after");
        chk("s4_drop_sticky", 32'(evt_drop), 1);

        // release glitch inside the debounce window restarts the long timer
        key_i[2] = 0; ticks(10);
        key_i[2] = 1; ticks(2);
        key_i[2] = 0; ticks(14);
        chk("s5_held", 32'(key_state[2]), 1);
        exp_q.push_back(ev(2, PRESS));
        check_events("s5_no_long_yet");
        ticks(8);
        exp_q.push_back(ev(2, LNG));
        check_events("s5_long");
        key_i[2] = 1; ticks(12);
        exp_q.push_back(ev(2, REL));
        check_events("s5_release");

        // reset mid-LONG with the key still down: re-qualify, no RELEASE for the old press
        key_i[3] = 0; ticks(30);
        exp_q.push_back(ev(3, PRESS)); exp_q.push_back(ev(3, LNG));
        check_events("s6_before");
        rst = 1; tick(); rst = 0;
        chk("s6_rst_valid", 32'(evt_valid), 0);
        chk("s6_rst_state", 32'(key_state), 0);
        chk("s6_rst_drop", 32'(evt_drop), 0);
        // post lands 6 edges after the reset edge, visible one edge later
        wait_valid(n);
        chk("s6_press_lat", n, 7);
        chk("s6_press_key", 32'(evt_key), 3);
        chk("s6_press_code", 32'(evt_code), PRESS);
        ticks(5); key_i[3] = 1; ticks(12);
        exp_q.push_back(ev(3, PRESS)); exp_q.push_back(ev(3, REL));
        check_events("s6_after");

        // random phase: busy then slower key activity, random ready, rare reset
        for (int c = 0; c < 4000; c++) begin
            for (int k = 0; k < NK; k++)
                if ($urandom_range(0, 99) < ((c < 2000) ? 6 : 2)) key_i[k] = ~key_i[k];
            evt_ready = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 999) == 0);
            tick();
        end
        rst = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
